muldiv_sequencer: RTL and testbench

Iterative sequencer for the RV32M multiply/divide extension, sitting in the execute stage next to the ALU. The decoder routes M-extension instructions here instead of to the single-cycle ALU. The block accepts one operation at a time, runs a radix-2 shift-add multiply or restoring divide over 32 cycles, and holds the pipeline through `stall` until the result is ready. Special divide cases complete on a short path.

---
 rtl/muldiv_sequencer_if.sv | 22 ++
 rtl/muldiv_sequencer.sv | 139 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the M-extension sequencer.
// The master side issues operations; the slave side is the sequencer itself.
interface muldiv_sequencer_if;
  logic        start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  modport master (
    output start, Funct3, SrcA, SrcB,
    input  stall, busy, done, Result
  );

  modport slave (
    input  start, Funct3, SrcA, SrcB,
    output stall, busy, done, Result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide: radix-2 shift-add multiply and restoring divide over
// 32 cycles, with a short path for divide-by-zero and signed overflow.
module muldiv_sequencer (
  input logic               clk,
  input logic               rst_n,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;       // multiplicand, or dividend shifting out / quotient shifting in
  logic [31:0] b_q;
  logic [63:0] acc_q;
  logic [31:0] rem_q;
  logic [5:0]  cnt_q;
  logic        sign_a_q, sign_b_q;
  logic        busy_q, done_q;
  logic [31:0] result_q;

  logic        sign_a_d, sign_b_d;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic [63:0] product;
  logic [31:0] quotient, remainder;
  logic [31:0] fix_result, special_result;
  logic        div_by_zero, div_ovf, special;

  always_comb begin
    sign_a_d = 1'b0;
    sign_b_d = 1'b0;
    case (op_q)
      3'b001, 3'b100, 3'b110: begin
        sign_a_d = a_q[31];
        sign_b_d = b_q[31];
      end
      3'b010:  sign_a_d = a_q[31];
      default: ;
    endcase
    mag_a = sign_a_d ? -a_q : a_q;
    mag_b = sign_b_d ? -b_q : b_q;

    div_by_zero    = (b_q == 32'd0);
    div_ovf        = ~op_q[0] & (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF);
    special        = op_q[2] & (div_by_zero | div_ovf);
    special_result = div_by_zero ? (op_q[1] ? a_q : 32'hFFFF_FFFF)
                                 : (op_q[1] ? 32'd0 : 32'h8000_0000);

    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    // Partial remainder stays below the divisor, so 33 bits hold shift and difference.
    div_shift = {rem_q, a_q[31]};
    div_diff  = div_shift - {1'b0, b_q};

    product   = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quotient  = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
    remainder = sign_a_q ? -rem_q : rem_q;

    unique case (op_q)
      3'b000:                 fix_result = product[31:0];
      3'b001, 3'b010, 3'b011: fix_result = product[63:32];
      3'b100, 3'b101:         fix_result = quotient;
      default:                fix_result = remainder;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      rem_q    <= 32'd0;
      cnt_q    <= 6'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            op_q    <= bus.Funct3;
            a_q     <= bus.SrcA;
            b_q     <= bus.SrcB;
            busy_q  <= 1'b1;
            state_q <= StPrep;
          end else begin
            state_q <= StIdle;
          end
        end
        StPrep: begin
          sign_a_q <= sign_a_d;
          sign_b_q <= sign_b_d;
          a_q      <= mag_a;
          b_q      <= mag_b;
          acc_q    <= {32'd0, mag_b};
          rem_q    <= 32'd0;
          cnt_q    <= 6'd0;
          if (special) begin
            result_q <= special_result;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else begin
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (op_q[2]) begin
            rem_q <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
            a_q   <= {a_q[30:0], ~div_diff[32]};
          end else begin
            acc_q <= {mul_sum, acc_q[31:1]};
          end
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= StFix;
        end
        StFix: begin
          result_q <= fix_result;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.stall  = busy_q | (bus.start & ((state_q == StIdle) | (state_q == StDone)));
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected results are queued at issue and
// compared when done pulses, together with latency and handshake flags.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    bus.start  = 1'b1;
    bus.Funct3 = f;
    bus.SrcA   = a;
    bus.SrcB   = b;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    tag_q.push_back(tag);
  endtask

  // Counts rising edges until done; cycles before done must show busy and stall.
  // At the first edge the operands are replaced by nf/na/nb to prove they were latched.
  task automatic wait_done(input int pulse_at, input bit hold, input logic [2:0] nf,
                           input logic [31:0] na, input logic [31:0] nb,
                           output int n, output int bad);
    n   = 0;
    bad = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus.Funct3 = nf;
        bus.SrcA   = na;
        bus.SrcB   = nb;
      end
      if (!hold) bus.start = (n == pulse_at);
      if (!bus.done && !(bus.busy && bus.stall)) bad++;
    end while (!bus.done && n < 80);
  endtask

  task automatic finish_op(input int n, input int bad, input bit expect_stall);
    logic [31:0] exp;
    int          lat;
    string       tag;
    if (!bus.done) begin
      check("timeout_done", {31'd0, bus.done}, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      lat = lat_q.pop_front();
      tag = tag_q.pop_front();
      check({tag, "_result"}, bus.Result, exp);
      check({tag, "_latency"}, n, lat);
      check({tag, "_busy_stall_cycles_bad"}, bad, 32'd0);
      check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_stall_at_done"}, {31'd0, bus.stall}, {31'd0, expect_stall});
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag,
                        input int pulse_at);
    int n, bad;
    @(negedge clk);
    drive(f, a, b, exp, lat, tag);
    #1;
    check({tag, "_stall_at_accept"}, {31'd0, bus.stall}, 32'd1);
    wait_done(pulse_at, 1'b0, 3'($urandom_range(7, 0)), $urandom, $urandom, n, bad);
    finish_op(n, bad, 1'b0);
  endtask

  initial begin
    int n, bad;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.Funct3 = 3'd0;
    bus.SrcA   = 32'd0;
    bus.SrcB   = 32'd0;
    #1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check("reset_result", bus.Result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, "mul_7_m3", -1);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, "mulh", -1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, "mulhsu", -1);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, "mulhu", -1);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, "div_m7_2", -1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, "rem_m7_2", -1);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 35, "divu_pulse", 10);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 35, "remu", -1);

    run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "divu_by0", -1);
    run_op(3'b111, 32'd5, 32'd0, 32'd5, 2, "remu_by0", -1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf", -1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf", -1);

    // Back-to-back: start stays high, second op is accepted at the DONE edge.
    @(negedge clk);
    drive(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, "b2b_first");
    exp_q.push_back(32'hFFFF_FFFF);
    lat_q.push_back(35);
    tag_q.push_back("b2b_second");
    wait_done(-1, 1'b1, 3'b110, 32'hFFFF_FFF9, 32'd2, n, bad);
    finish_op(n, bad, 1'b1);
    wait_done(-1, 1'b0, 3'b000, $urandom, $urandom, n, bad);
    finish_op(n, bad, 1'b0);

    // Asynchronous reset mid-cycle while the counter is at 15.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.SrcA   = 32'h1234_5678;
    bus.SrcB   = 32'h0000_0101;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_stall", {31'd0, bus.stall}, 32'd0);
    check("arst_result", bus.Result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 35, "mul_3_4_after_rst", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
